// File: rtl/mem_sweep_pkg.sv
// Shared types and the pattern generator for the memory fill/verify sweeper.
package mem_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        VERIFY = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PAT_ONES    = 2'd0,
        PAT_ADDR    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_ZEROS   = 2'd3
    } pattern_t;

    localparam int MAX_WID = 64;

    // Generated at MAX_WID; callers truncate to their word width.
    function automatic logic [MAX_WID-1:0] expected_word(input logic [31:0] addr,
                                                         input pattern_t    pat);
        logic [MAX_WID-1:0] w;
        case (pat)
            PAT_ONES:    w = '1;
            PAT_ADDR:    w = MAX_WID'(addr);
            PAT_CHECKER: w = addr[0] ? {(MAX_WID/2){2'b10}} : {(MAX_WID/2){2'b01}};
            default:     w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_sweep_checker.sv
// Read-back compare stage: one-cycle (valid, addr) pipeline aligned with the
// registered RAM output, saturating mismatch counter and first-error capture.
module mem_sweep_checker
    import mem_sweep_pkg::*;
#(
    parameter int WID_MEM = 2,
    parameter int ADDR_W  = 32,
    parameter int CW      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               rd_valid,
    input  logic [CW-1:0]      rd_addr,
    input  pattern_t           pat,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic [31:0]        err_count,
    output logic [ADDR_W-1:0]  first_err_addr
);

    logic               vld_q;
    logic [CW-1:0]      addr_q;
    logic [31:0]        err_count_q;
    logic [ADDR_W-1:0]  first_q;
    logic [WID_MEM-1:0] exp_word;
    logic               mismatch;

    always_comb begin
        exp_word = WID_MEM'(expected_word(32'(addr_q), pat));
        mismatch = vld_q && (mem_dout != exp_word);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            vld_q       <= 1'b0;
            addr_q      <= '0;
            err_count_q <= '0;
            first_q     <= '0;
        end else begin
            vld_q  <= rd_valid;
            addr_q <= rd_addr;
            if (mismatch) begin
                if (err_count_q != 32'hFFFF_FFFF)
                    err_count_q <= err_count_q + 32'd1;
                // Only the first failure of a sweep records its address.
                if (err_count_q == 32'd0)
                    first_q <= ADDR_W'(addr_q);
            end
        end
    end

    assign err_count      = err_count_q;
    assign first_err_addr = first_q;

endmodule

// File: rtl/mem_sweep_ctrl.sv
// Fill/verify sweeper owning the RAM port pair; grants the port to a single
// user requester while idle.
module mem_sweep_ctrl
    import mem_sweep_pkg::*;
#(
    parameter int WID_MEM   = 2,
    parameter int DEPTH_MEM = 65536,
    parameter int ADDR_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         pattern_sel,
    output logic               busy,
    output logic               done,
    output logic [31:0]        err_count,
    output logic               err_flag,
    output logic [ADDR_W-1:0]  first_err_addr,
    input  logic               user_req,
    input  logic               user_we,
    input  logic [ADDR_W-1:0]  user_addr,
    input  logic [WID_MEM-1:0] user_din,
    output logic               user_gnt,
    output logic [WID_MEM-1:0] user_rdata,
    output logic [ADDR_W-1:0]  mem_raddr,
    output logic [ADDR_W-1:0]  mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    output logic               mem_we,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic [2:0]         dbg_state
);

    localparam int            CW   = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH_MEM - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    pattern_t      pat_q;
    logic          accept;
    logic          at_last;

    assign accept  = start && (state_q == IDLE);
    assign at_last = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = FILL;
            FILL:    if (at_last) state_d = VERIFY;
            VERIFY:  if (at_last) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The counter restarts at zero between FILL and VERIFY rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            pat_q <= PAT_ONES;
        end else if (accept) begin
            cnt_q <= '0;
            pat_q <= pattern_t'(pattern_sel);
        end else if (state_q == FILL) begin
            cnt_q <= at_last ? '0 : cnt_q + 1'b1;
        end else if (state_q == VERIFY && !at_last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        user_gnt  = 1'b0;
        mem_we    = 1'b0;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_din   = '0;
        case (state_q)
            IDLE: begin
                if (user_req && !start) begin
                    user_gnt  = 1'b1;
                    mem_raddr = user_addr;
                    mem_waddr = user_addr;
                    mem_din   = user_din;
                    mem_we    = user_we;
                end
            end
            FILL: begin
                mem_we    = 1'b1;
                mem_waddr = ADDR_W'(cnt_q);
                mem_din   = WID_MEM'(expected_word(32'(cnt_q), pat_q));
            end
            VERIFY:  mem_raddr = ADDR_W'(cnt_q);
            default: ;
        endcase
    end

    mem_sweep_checker #(
        .WID_MEM (WID_MEM),
        .ADDR_W  (ADDR_W),
        .CW      (CW)
    ) u_chk (
        .clk            (clk),
        .reset          (reset),
        .clear          (accept),
        .rd_valid       (state_q == VERIFY),
        .rd_addr        (cnt_q),
        .pat            (pat_q),
        .mem_dout       (mem_dout),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    assign err_flag   = (err_count != 32'd0);
    assign user_rdata = mem_dout;
    assign dbg_state  = state_q;

endmodule

// File: doc/mem_sweep_ctrl.md
Name: mem_sweep_ctrl

Overview:
- Sequencer that owns the single write/read port pair of a block-RAM instance (WID_MEM x DEPTH_MEM, 1-cycle registered read).
- On start it fills every word with a selected pattern, then reads every word back and checks it against the same pattern. It reports a mismatch count and the address of the first failure.
- While idle it grants the port to a single user requester, so the memory can be reinitialised and verified in place between user accesses.

Parameters:
- WID_MEM, 2, data width of one memory word.
- DEPTH_MEM, 65536, number of words; address sweep runs 0..DEPTH_MEM-1.
- ADDR_W, 32, width of every address port.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins fill+verify sweep.
- pattern_sel  in  2  pattern code, sampled on accepted start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at sweep end.
- err_count  out  32  verify mismatches, saturating.
- err_flag  out  1  err_count != 0.
- first_err_addr  out  ADDR_W  address of first mismatch in last sweep.
- user_req  in  1  user access request.
- user_we  in  1  1 = write, 0 = read.
- user_addr  in  ADDR_W  user address.
- user_din  in  WID_MEM  user write data.
- user_gnt  out  1  combinational grant.
- user_rdata  out  WID_MEM  mem_dout passthrough; valid the cycle after a granted read.
- mem_raddr  out  ADDR_W  to memory read address.
- mem_waddr  out  ADDR_W  to memory write address.
- mem_din  out  WID_MEM  to memory write data.
- mem_we  out  1  memory write enable.
- mem_dout  in  WID_MEM  memory registered read data, 1-cycle latency.

Behaviour:
- Reset: state IDLE; busy=0, done=0, err_count=0, err_flag=0, first_err_addr=0, mem_we=0, mem_raddr=0, mem_waddr=0, mem_din=0. Reset mid-sweep aborts immediately; memory contents are then undefined.
- States and transitions:
  - IDLE -> FILL on start=1.
  - FILL -> VERIFY after writing address DEPTH_MEM-1.
  - VERIFY -> DRAIN after issuing read of DEPTH_MEM-1.
  - DRAIN -> DONE after 1 cycle.
  - DONE -> IDLE after 1 cycle.
- Start acceptance:
  - start is honoured only in IDLE; start in any other state is ignored.
  - On accept: latch pattern_sel, clear err_count and first_err_addr, reset the sweep counter to 0.
- FILL: one write per cycle; mem_we=1, mem_waddr=cnt, mem_din=expected(cnt, pat).
- VERIFY: mem_we=0, mem_raddr=cnt, one read per cycle. Compare pipeline holds (valid, addr) for one cycle; mem_dout is compared with expected(addr) in the following cycle (including DRAIN).
- On mismatch:
  - err_count increments, saturating at 32'hFFFF_FFFF.
  - If err_count was 0 (first error of this sweep), capture first_err_addr=addr.
- Latency: done asserts exactly 2*DEPTH_MEM+2 cycles after the start cycle. busy=1 in FILL, VERIFY, DRAIN and DONE.
- Patterns, expected(a, pat):
  - 0 = all ones.
  - 1 = a[WID_MEM-1:0].
  - 2 = checkerboard: {..0101} if a[0]=0, else {..1010}.
  - 3 = all zeros.
- Arbitration:
  - user_gnt = user_req & (state==IDLE) & ~start; a sweep start wins a simultaneous user request.
  - When granted: mem_raddr=user_addr, mem_waddr=user_addr, mem_din=user_din, mem_we=user_we.
  - When not granted in IDLE: mem_we=0.
- Counter: internal sweep counter is clog2(DEPTH_MEM) bits, zero-extended onto ADDR_W ports. The terminal-count compare uses DEPTH_MEM-1, and the counter never wraps inside a sweep.
- err_count and first_err_addr hold their values after done until the next accepted start.

Decomposition:
- Package mem_sweep_pkg holds:
  - state_t enum (IDLE, FILL, VERIFY, DRAIN, DONE).
  - pattern_t enum (PAT_ONES, PAT_ADDR, PAT_CHECKER, PAT_ZEROS).
  - function expected_word(addr, pat), parameterised by width.
- One sub-module, mem_sweep_checker: the 1-cycle compare pipeline plus the saturating error counter and first-error capture.
- Top-level mem_sweep_ctrl holds the FSM, address counter and port mux, and drives a memory instance that has write enable.

Test Plan:
- Sim parameters DEPTH_MEM=16, WID_MEM=2, clean memory model. pulse start, pattern_sel=2 -> 16 writes alternating 2'b01/2'b10, done at cycle 34 after start, err_count=0, err_flag=0.
- Model forces mem_dout bit flip at address 5 and 9 during VERIFY -> err_count=2, first_err_addr=5, err_flag=1.
- user_req=1 with user_we=1, addr=3, din=2'b11 in IDLE, then a read of addr 3 -> user_gnt=1 both cycles, user_rdata=2'b11 one cycle after the read grant.
- start and user_req in the same IDLE cycle -> user_gnt=0, busy=1 next cycle, no user write reaches memory.
- start re-pulsed during VERIFY -> ignored, done still at cycle 34. reset asserted at cycle 10 of FILL -> next cycle IDLE, busy=0, mem_we=0, err_count=0.
- Force err_count preload to 32'hFFFF_FFFE, inject 3 mismatches -> err_count saturates at 32'hFFFF_FFFF.
